// File: rtl/decision_wait_pkg.sv
// Shared types and helpers for the decision-wait element.
//   dw_state_e  : FSM states (S_IDLE / S_HOLD); only four-phase mode leaves S_IDLE
//   MAX_CH      : widest supported channel count
//   pick_lowest : isolates the lowest set bit of a MAX_CH-wide vector (one-hot result)
//   popcnt_gt1  : true when more than one bit of the vector is set
package decision_wait_pkg;

    localparam int MAX_CH = 16;

    localparam logic [MAX_CH-1:0] VEC_ONE = MAX_CH'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } dw_state_e;

    // x & -x keeps only the lowest set bit.
    function automatic logic [MAX_CH-1:0] pick_lowest(input logic [MAX_CH-1:0] vec);
        return vec & (~vec + VEC_ONE);
    endfunction

    // Clearing the lowest set bit leaves something only if there were two or more.
    function automatic logic popcnt_gt1(input logic [MAX_CH-1:0] vec);
        return (vec & (vec - VEC_ONE)) != '0;
    endfunction

endpackage

// File: rtl/dw_pick_lowest.sv
// Priority selector: lowest set bit wins.
//   i_vec    in  N_CH  candidate requests
//   o_onehot out N_CH  one-hot copy of the winning bit (zero if none)
//   o_idx    out IW    index of the winning bit (zero if none)
//   o_any    out 1     at least one candidate present
//   o_multi  out 1     more than one candidate present
module dw_pick_lowest
    import decision_wait_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int IW   = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] i_vec,
    output logic [N_CH-1:0] o_onehot,
    output logic [IW-1:0]   o_idx,
    output logic            o_any,
    output logic            o_multi
);

    logic [MAX_CH-1:0] w_vec_ext;
    logic [MAX_CH-1:0] w_pick_ext;
    logic [IW-1:0]     w_idx_terms [N_CH];

    always_comb begin
        w_vec_ext             = '0;
        w_vec_ext[N_CH-1:0]   = i_vec;
    end

    assign w_pick_ext = pick_lowest(w_vec_ext);
    assign o_onehot   = w_pick_ext[N_CH-1:0];
    // Upper bits of the pick are always zero, so OR-ing the whole word is exact.
    assign o_any      = |w_pick_ext;
    assign o_multi    = popcnt_gt1(w_vec_ext);

    // One-hot to binary: each bit contributes its own index when it is the winner.
    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_idx_term
            assign w_idx_terms[gi] = w_pick_ext[gi] ? IW'(gi) : '0;
        end
    endgenerate

    always_comb begin
        o_idx = '0;
        for (int k = 0; k < N_CH; k++) begin
            o_idx = o_idx | w_idx_terms[k];
        end
    end

endmodule

// File: rtl/decision_wait_nch.sv
// N-channel decision-wait element (clocked emulation of an async decision-wait).
// A shared fire request rendezvouses with one channel request a[i]; z[i] acknowledges.
//   clk       in   1     clock
//   rstn      in   1     synchronous active-low reset
//   fire      in   1     shared request (transition in two-phase, level in four-phase)
//   a         in   N_CH  channel requests (mutually exclusive by protocol)
//   err_clr   in   1     clears the sticky error flag
//   z         out  N_CH  registered channel acknowledges
//   fire_ack  out  1     two-phase: XOR of z; four-phase: OR of z
//   waiting   out  1     fire pending with no channel to serve yet
//   grant_idx out  IW    registered index of the last channel served
//   err       out  1     mutual-exclusion / protocol violation flag
module decision_wait_nch
    import decision_wait_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int FOUR_PHASE = 0,
    parameter int ERR_STICKY = 1,
    parameter int IW         = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            fire,
    input  logic [N_CH-1:0] a,
    input  logic            err_clr,
    output logic [N_CH-1:0] z,
    output logic            fire_ack,
    output logic            waiting,
    output logic [IW-1:0]   grant_idx,
    output logic            err
);

    dw_state_e       r_state_reg;
    dw_state_e       w_state_next;
    logic [N_CH-1:0] r_z_reg;
    logic [N_CH-1:0] w_z_next;
    logic [IW-1:0]   r_grant_reg;
    logic [IW-1:0]   w_grant_next;
    logic            r_err_reg;
    logic            w_viol;

    logic [N_CH-1:0] w_pick_in;
    logic [N_CH-1:0] w_onehot;
    logic [IW-1:0]   w_idx;
    logic            w_any;
    logic            w_multi;
    logic            w_waiting;
    logic            w_fire_ack;

    dw_pick_lowest #(
        .N_CH (N_CH),
        .IW   (IW)
    ) u_pick (
        .i_vec    (w_pick_in),
        .o_onehot (w_onehot),
        .o_idx    (w_idx),
        .o_any    (w_any),
        .o_multi  (w_multi)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state_reg <= S_IDLE;
        end else begin
            r_state_reg <= w_state_next;
        end
    end

    // Acknowledge, grant index and error registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_z_reg     <= '0;
            r_grant_reg <= '0;
            r_err_reg   <= 1'b0;
        end else begin
            r_z_reg     <= w_z_next;
            r_grant_reg <= w_grant_next;
            // Set wins over clear when both happen in the same cycle.
            r_err_reg   <= (ERR_STICKY != 0) ? ((r_err_reg & ~err_clr) | w_viol) : w_viol;
        end
    end

    generate
        if (FOUR_PHASE == 0) begin : g_two_phase
            logic w_fire_pend;

            // A side is pending while its level differs from the ack parity it expects.
            assign w_pick_in   = a ^ r_z_reg;
            assign w_fire_pend = fire ^ (^r_z_reg);

            // Two-phase operation never leaves S_IDLE.
            always_comb begin
                w_state_next = r_state_reg;
            end

            always_comb begin
                w_z_next     = r_z_reg;
                w_grant_next = r_grant_reg;
                w_viol       = 1'b0;
                if (w_fire_pend && w_any) begin
                    w_z_next     = r_z_reg ^ w_onehot;
                    w_grant_next = w_idx;
                    w_viol       = w_multi;
                end
            end

            assign w_waiting  = w_fire_pend & ~w_any;
            assign w_fire_ack = ^r_z_reg;
        end else begin : g_four_phase
            logic r_seen_reg;
            logic w_seen_next;
            logic w_other;
            logic w_release;

            assign w_pick_in = a;
            // In S_HOLD r_z_reg is the one-hot of the served channel.
            assign w_other   = |(a & ~r_z_reg);
            assign w_release = ~fire & ~(|(a & r_z_reg));

            always_comb begin
                w_state_next = r_state_reg;
                case (r_state_reg)
                    S_IDLE:  if (fire && w_any) w_state_next = S_HOLD;
                    S_HOLD:  if (w_release)     w_state_next = S_IDLE;
                    default: w_state_next = S_IDLE;
                endcase
            end

            // r_seen_reg remembers that a foreign request is already reported, so a
            // request held high across several cycles counts as a single violation.
            always_comb begin
                w_z_next     = r_z_reg;
                w_grant_next = r_grant_reg;
                w_viol       = 1'b0;
                w_seen_next  = 1'b0;
                case (r_state_reg)
                    S_IDLE: begin
                        if (fire && w_any) begin
                            w_z_next     = w_onehot;
                            w_grant_next = w_idx;
                            w_viol       = w_multi;
                            w_seen_next  = w_multi;
                        end
                    end
                    S_HOLD: begin
                        w_viol      = w_other & ~r_seen_reg;
                        w_seen_next = w_other;
                        if (w_release) begin
                            w_z_next = '0;
                        end
                    end
                    default: begin
                        w_z_next = '0;
                    end
                endcase
            end

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    r_seen_reg <= 1'b0;
                end else begin
                    r_seen_reg <= w_seen_next;
                end
            end

            assign w_waiting  = (r_state_reg == S_IDLE) & fire & ~(|a);
            assign w_fire_ack = |r_z_reg;
        end
    endgenerate

    assign z         = r_z_reg;
    assign grant_idx = r_grant_reg;
    assign err       = r_err_reg;
    assign waiting   = w_waiting;
    assign fire_ack  = w_fire_ack;

endmodule
